// File: rtl/rr_prio_enc.sv
// rr_prio_enc: registered priority encoder with a valid/ready handshake on
// both sides. It selects either the highest set index (MODE=0) or the first
// set bit at or after a rotating pointer (MODE=1). There is a single output
// register stage and no skid buffer, so req_ready follows the output slot.
module rr_prio_enc #(
    parameter int CODE_WIDTH = 2,
    parameter int MODE       = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2**CODE_WIDTH-1:0] req_data,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [CODE_WIDTH-1:0]   code,
    output logic                    code_none,
    output logic                    code_valid,
    input  logic                    code_ready
);

    localparam int N = 2**CODE_WIDTH;

    logic [CODE_WIDTH-1:0] code_reg;
    logic                  code_none_reg;
    logic                  code_valid_reg;
    logic [CODE_WIDTH-1:0] ptr_reg;

    logic [CODE_WIDTH-1:0] code_next;
    logic                  code_none_next;
    logic [CODE_WIDTH-1:0] ptr_next;

    logic                  accept;
    logic                  any_req;

    // Request vector rotated so that bit 0 is the bit the pointer selects.
    logic [CODE_WIDTH-1:0] rot_idx [N];
    logic [N-1:0]          rot_req;

    logic [CODE_WIDTH-1:0] fp_code;
    logic [CODE_WIDTH-1:0] rr_offset;
    logic [CODE_WIDTH-1:0] rr_code;

    assign req_ready = !code_valid_reg || code_ready;
    assign accept    = req_valid && req_ready;
    assign any_req   = |req_data;

    // Each rotated position maps back to (position + ptr) mod N. The modulo
    // comes for free from the CODE_WIDTH-bit add.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot_idx[gi] = CODE_WIDTH'(gi) + ptr_reg;
            assign rot_req[gi] = req_data[rot_idx[gi]];
        end
    endgenerate

    // Fixed priority: the highest set index wins. The ascending scan lets
    // later (higher) bits override earlier ones.
    always_comb begin
        fp_code = '0;
        for (int i = 0; i < N; i++) begin
            if (req_data[i]) begin
                fp_code = CODE_WIDTH'(i);
            end
        end
    end

    // Round-robin: the lowest set bit of the rotated vector is the first
    // request found when scanning from ptr upward with wrap-around.
    always_comb begin
        rr_offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                rr_offset = CODE_WIDTH'(i);
            end
        end
        rr_code = rr_offset + ptr_reg;
    end

    // Result selection and pointer advance. An all-zero vector reports
    // code 0 with code_none set and leaves the pointer where it was.
    always_comb begin
        code_next      = '0;
        code_none_next = !any_req;
        ptr_next       = ptr_reg;
        if (any_req) begin
            code_next = (MODE == 1) ? rr_code : fp_code;
            if (MODE == 1) begin
                ptr_next = rr_code + CODE_WIDTH'(1);
            end
        end
        if (MODE != 1) begin
            ptr_next = '0;
        end
    end

    // Output stage: load on accept, drop valid when consumed with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_reg       <= '0;
            code_none_reg  <= 1'b0;
            code_valid_reg <= 1'b0;
            ptr_reg        <= '0;
        end else if (accept) begin
            code_reg       <= code_next;
            code_none_reg  <= code_none_next;
            code_valid_reg <= 1'b1;
            ptr_reg        <= ptr_next;
        end else if (code_ready) begin
            code_valid_reg <= 1'b0;
        end
    end

    assign code       = code_reg;
    assign code_none  = code_none_reg;
    assign code_valid = code_valid_reg;

endmodule

// File: doc/rr_prio_enc.md
RR_PRIO_ENC -- requirements
Module: rr_prio_enc

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 2: code width in bits; legal range 1..6; request width N = 2**CODE_WIDTH.
REQ-002 SHALL have parameter MODE, default 1: 0 = fixed priority, highest set index wins; 1 = round-robin.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port req_data, input, N bits: request vector.
REQ-007 SHALL have port req_valid, input, 1 bit: req_data valid.
REQ-008 SHALL have port req_ready, output, 1 bit: block accepts req_data this cycle.
REQ-009 SHALL have port code, output, CODE_WIDTH bits: encoded winning index.
REQ-010 SHALL have port code_none, output, 1 bit: the accepted vector was all-zero.
REQ-011 SHALL have port code_valid, output, 1 bit: code and code_none are valid.
REQ-012 SHALL have port code_ready, input, 1 bit: the consumer takes the output this cycle.

Function
REQ-013 SHALL accept a request (handshake) on any rising clk edge where req_valid=1 and req_ready=1.
REQ-014 SHALL drive req_ready = !code_valid || code_ready, combinationally: one output stage, no skid buffer.
REQ-015 SHALL register the result of each accepted request into code/code_none and set code_valid=1 on the same edge: latency 1 cycle, throughput 1 result/cycle.
REQ-016 SHALL clear code_valid on an edge where code_valid=1, code_ready=1 and no new request is accepted.
REQ-017 SHALL hold code and code_none stable while code_valid=1 and code_ready=0.
REQ-018 SHALL, in MODE=0, select the highest index i with req_data[i]=1.
REQ-019 SHALL, in MODE=1, keep a CODE_WIDTH-bit pointer ptr and select the first set bit scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
REQ-020 SHALL, in MODE=1, update ptr to (winner+1) mod N on each accepted non-zero request; ptr N-1 wraps to 0.
REQ-021 SHALL, for an accepted all-zero req_data, set code=0 and code_none=1, leave ptr unchanged, and still assert code_valid.
REQ-022 SHALL hold ptr at 0 in MODE=0.
REQ-023 SHALL, with CODE_WIDTH=1, behave identically to the above rules for N=2.
REQ-024 SHALL accept a new request and release the old result on the same edge (simultaneous code_ready=1 and accept); code_valid then stays 1 with the new result.
REQ-025 SHALL ignore req_data whenever no handshake occurs: no state change.

Reset
REQ-026 SHALL, while rst_n=0, force code_valid=0, code=0, code_none=0 and ptr=0 immediately, independent of clk.
REQ-027 SHALL drive req_ready=1 during and after reset, because code_valid=0.
REQ-028 SHALL discard any in-flight result when reset asserts mid-operation; the first accept after deassertion scans from ptr=0.
REQ-029 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Verification
REQ-030 Reset: rst_n=0 asynchronously while code_valid=1 -> code_valid=0, code=0, code_none=0, req_ready=1 with no clk edge.
REQ-031 MODE=0, CODE_WIDTH=2: accept req_data=4'b0110 -> next cycle code=2, code_none=0, code_valid=1; then accept 4'b0001 -> code=0.
REQ-032 MODE=1, CODE_WIDTH=2: hold req_data=4'b1111, req_valid=1, code_ready=1 for 5 cycles -> codes 0,1,2,3,0 on consecutive cycles.
REQ-033 MODE=1, CODE_WIDTH=2, wrap-around: after a grant of 2 (ptr=3), accept 4'b0011 -> code=0 and ptr=1; then accept 4'b0011 -> code=1.
REQ-034 Backpressure: code_valid=1, code_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and code unchanged; code_ready=1 -> old result consumed and new request accepted on the same edge.
REQ-035 Zero input: accept 4'b0000 in MODE=1 with ptr=2 -> code=0, code_none=1, code_valid=1, ptr stays 2.
